// File: rtl/booth_mul_arb.sv
// Round-robin arbiter sharing one booth_mul between two requesters.
// Optional macro BOOTH_ARB_ZERO_SKIP_EN bypasses the multiplier when an operand is zero.
module booth_mul_arb #(
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 17,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  output logic               gnt0,
  output logic               done0,
  output logic [2*WIDTH-1:0] res0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt1,
  output logic               done1,
  output logic [2*WIDTH-1:0] res1,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_m,
  output logic [WIDTH-1:0]   mul_q,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic               done0_q, done0_d, done1_q, done1_d;
  logic               busy_q, busy_d;
  logic               mul_start_q, mul_start_d;
  logic [WIDTH-1:0]   mul_m_q, mul_m_d, mul_q_q, mul_q_d;
  logic [2*WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;

  logic               sel;
  logic [WIDTH-1:0]   sel_a, sel_b;

`ifdef BOOTH_ARB_ZERO_SKIP_EN
  logic               zero_q, zero_d;
`endif

  // On a tie the requester that was not served last wins.
  always_comb begin
    sel   = (req0 && req1) ? ~last_q : req1;
    sel_a = sel ? a1 : a0;
    sel_b = sel ? b1 : b0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mul_m_d     = mul_m_q;
    mul_q_d     = mul_q_q;
    res0_d      = res0_q;
    res1_d      = res1_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    mul_start_d = 1'b0;
`ifdef BOOTH_ARB_ZERO_SKIP_EN
    zero_d      = zero_q;
`endif

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = sel;
          mul_m_d = sel_a;
          mul_q_d = sel_b;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          state_d = START;
`ifdef BOOTH_ARB_ZERO_SKIP_EN
          zero_d      = (sel_a == '0) || (sel_b == '0);
          mul_start_d = ~zero_d;
`else
          mul_start_d = 1'b1;
`endif
        end
      end

      START: begin
`ifdef BOOTH_ARB_ZERO_SKIP_EN
        if (zero_q) begin
          if (owner_q) res1_d = '0;
          else         res0_d = '0;
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(MUL_LAT - 1);
          state_d = WAIT;
        end
`else
        cnt_d   = CNT_W'(MUL_LAT - 1);
        state_d = WAIT;
`endif
      end

      // booth_mul has no done flag, so the product is taken on a fixed count.
      WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q) res1_d = mul_result;
          else         res0_d = mul_result;
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      mul_m_q     <= '0;
      mul_q_q     <= '0;
      res0_q      <= '0;
      res1_q      <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BOOTH_ARB_ZERO_SKIP_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mul_m_q     <= mul_m_d;
      mul_q_q     <= mul_q_d;
      res0_q      <= res0_d;
      res1_q      <= res1_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      mul_start_q <= mul_start_d;
      busy_q      <= busy_d;
`ifdef BOOTH_ARB_ZERO_SKIP_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign res0      = res0_q;
  assign res1      = res1_q;
  assign mul_start = mul_start_q;
  assign mul_m     = mul_m_q;
  assign mul_q     = mul_q_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_mul_arb.sv
// Directed bench for booth_mul_arb with a latency-accurate booth_mul model and result scoreboard.
// Zero-operand expectations follow BOOTH_ARB_ZERO_SKIP_EN when it is defined.
module tb_booth_mul_arb;

  localparam int WIDTH      = 16;
  localparam int MUL_LAT    = 17;
  localparam int CNT_W      = 5;
  // done becomes visible right after edge E0+MUL_LAT+1, i.e. it is sampled on edge E0+MUL_LAT+2.
  localparam int DONE_EDGES = MUL_LAT + 1;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, done0, done1, mul_start, busy;
  logic [31:0] res0, res1, mul_result;
  logic [15:0] mul_m, mul_q;

  booth_mul_arb #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0), .res0(res0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1), .res1(res1),
    .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
    .mul_result(mul_result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic [31:0] prod;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_res0 = '0, exp_res1 = '0;

  // Multiplier stand-in: product is valid only for the single cycle before edge S+MUL_LAT.
  int          mdl_cnt;
  logic [31:0] mdl_prod;
  logic signed [31:0] mdl_m, mdl_q;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mdl_cnt    <= 0;
      mdl_prod   <= '0;
      mul_result <= JUNK;
    end else if (mul_start) begin
      mdl_m       = $signed(mul_m);
      mdl_q       = $signed(mul_q);
      mdl_cnt    <= MUL_LAT - 1;
      mdl_prod   <= mdl_m * mdl_q;
      mul_result <= JUNK;
    end else if (mdl_cnt != 0) begin
      mdl_cnt    <= mdl_cnt - 1;
      mul_result <= (mdl_cnt == 1) ? mdl_prod : JUNK;
    end else begin
      mul_result <= JUNK;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [15:0] x0, input logic [15:0] y0,
                               input logic r1, input logic [15:0] x1, input logic [15:0] y1);
    req0 = r0; a0 = x0; b0 = y0;
    req1 = r1; a1 = x1; b1 = y1;
  endtask

  task automatic pushExp(input logic owner, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    logic signed [31:0] xs, ys;
    xs = $signed(x);
    ys = $signed(y);
    e.owner = owner;
    e.prod  = xs * ys;
    sb.push_back(e);
  endtask

  task automatic waitDone(input logic which, input int limit, output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!(which ? done1 : done0) && edges < limit);
    if (!(which ? done1 : done0))
      checkOutput(which ? "done1_timeout" : "done0_timeout", 64'd0, 64'd1);
  endtask

  // Scoreboard and invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (!n_rst) begin
      exp_res0 = '0;
      exp_res1 = '0;
    end else begin
      checkOutput("gnt_exclusive", {63'd0, gnt0 & gnt1}, 64'd0);
      checkOutput("done_exclusive", {63'd0, done0 & done1}, 64'd0);
      if (done0 || done1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", {62'd0, done1, done0}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("done_owner", {63'd0, done1}, {63'd0, mon_e.owner});
          if (mon_e.owner) exp_res1 = mon_e.prod;
          else             exp_res0 = mon_e.prod;
        end
      end
      checkOutput("res0_track", res0, exp_res0);
      checkOutput("res1_track", res1, exp_res1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    int   n;
    int   gcount;
    logic gseq [6];
    logic saw_gnt1, saw_done1, saw_done0, mm_changed, saw_ms;

    // Reset state
    applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
    repeat (22) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_res0", res0, 0);
    checkOutput("rst_mul_m", mul_m, 0);
    n_rst = 1'b1;

    // Single op from requester 0
    $display("[TB] single op");
    @(posedge clk); #1;
    applyStimulus(1, 16'h8011, 16'h0002, 0, 16'h0, 16'h0);
    pushExp(0, 16'h8011, 16'h0002);
    @(posedge clk); #1;
    checkOutput("t1_gnt0", gnt0, 1);
    checkOutput("t1_mul_start", mul_start, 1);
    checkOutput("t1_gnt1", gnt1, 0);
    checkOutput("t1_mul_m", mul_m, 16'h8011);
    checkOutput("t1_mul_q", mul_q, 16'h0002);
    checkOutput("t1_busy", busy, 1);
    applyStimulus(0, 16'h8011, 16'h0002, 0, 16'h0, 16'h0);
    @(posedge clk); #1;
    checkOutput("t1_gnt0_pulse", gnt0, 0);
    checkOutput("t1_start_pulse", mul_start, 0);
    checkOutput("t1_mul_m_held", mul_m, 16'h8011);
    waitDone(0, 40, lat);
    checkOutput("t1_latency", lat + 1, DONE_EDGES);
    checkOutput("t1_res0", res0, 32'hFFFF_0022);
    checkOutput("t1_res1", res1, 0);
    @(posedge clk); #1;
    checkOutput("t1_done_pulse", done0, 0);
    checkOutput("t1_idle_busy", busy, 0);

    // Both requesters high from reset release
    $display("[TB] simultaneous");
    n_rst = 1'b0;
    sb.delete();
    applyStimulus(1, 16'd3, 16'd5, 1, 16'hFFFF, 16'hFFFF);
    pushExp(0, 16'd3, 16'd5);
    pushExp(1, 16'hFFFF, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    waitDone(0, 40, lat);
    checkOutput("t2_first_latency", lat, DONE_EDGES + 1);
    checkOutput("t2_res0", res0, 32'h0000_000F);
    applyStimulus(0, 16'd3, 16'd5, 1, 16'hFFFF, 16'hFFFF);
    waitDone(1, 40, lat);
    checkOutput("t2_done_gap", lat, MUL_LAT + 3);
    checkOutput("t2_res1", res1, 32'h0000_0001);
    applyStimulus(0, 16'd3, 16'd5, 0, 16'hFFFF, 16'hFFFF);

    // Fairness over six back-to-back operations
    $display("[TB] fairness");
    @(posedge clk); #1;
    applyStimulus(1, 16'hFFFD, 16'h0064, 1, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 3; i++) begin
      pushExp(0, 16'hFFFD, 16'h0064);
      pushExp(1, 16'h7FFF, 16'h7FFF);
    end
    gcount = 0;
    n = 0;
    while (gcount < 6 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (gnt0 || gnt1) begin
        gseq[gcount] = gnt1;
        gcount++;
        if (gcount == 6) applyStimulus(0, 16'hFFFD, 16'h0064, 0, 16'h7FFF, 16'h7FFF);
      end
    end
    checkOutput("t3_grant_count", gcount, 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t3_grant%0d", i), {63'd0, gseq[i]}, i % 2);
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t3_drain", sb.size(), 0);
    checkOutput("t3_res0", res0, 32'hFFFF_FED4);
    checkOutput("t3_res1", res1, 32'h3FFF_0001);

    // Request from requester 1 while requester 0 is in flight
    $display("[TB] busy ignore");
    applyStimulus(1, 16'h0123, 16'h0010, 0, 16'h0, 16'h0);
    pushExp(0, 16'h0123, 16'h0010);
    @(posedge clk); #1;
    checkOutput("t4_gnt0", gnt0, 1);
    applyStimulus(0, 16'h0123, 16'h0010, 0, 16'h0, 16'h0);
    repeat (5) @(posedge clk);
    #1 applyStimulus(0, 16'h0123, 16'h0010, 1, 16'h5555, 16'h2222);
    @(posedge clk); #1;
    applyStimulus(0, 16'h0123, 16'h0010, 0, 16'h5555, 16'h2222);
    saw_gnt1 = 0; saw_done1 = 0; saw_done0 = 0; mm_changed = 0;
    for (int i = 0; i < 40; i++) begin
      if (!saw_done0 && (mul_m != 16'h0123 || mul_q != 16'h0010)) mm_changed = 1;
      saw_gnt1  |= gnt1;
      saw_done1 |= done1;
      saw_done0 |= done0;
      @(posedge clk); #1;
    end
    checkOutput("t4_no_gnt1", saw_gnt1, 0);
    checkOutput("t4_no_done1", saw_done1, 0);
    checkOutput("t4_done0", saw_done0, 1);
    checkOutput("t4_operands_held", mm_changed, 0);
    checkOutput("t4_res0", res0, 32'h0000_1230);

    // Reset in the middle of an operation
    $display("[TB] reset mid-op");
    applyStimulus(1, 16'h1111, 16'h2222, 0, 16'h0, 16'h0);
    pushExp(0, 16'h1111, 16'h2222);
    @(posedge clk); #1;
    checkOutput("t5_gnt0", gnt0, 1);
    applyStimulus(0, 16'h1111, 16'h2222, 0, 16'h0, 16'h0);
    repeat (5) @(posedge clk);
    #1;
    sb.delete();
    n_rst = 1'b0;
    #1;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_res0", res0, 0);
    checkOutput("t5_res1", res1, 0);
    checkOutput("t5_mul_m", mul_m, 0);
    checkOutput("t5_mul_q", mul_q, 0);
    checkOutput("t5_flags", {60'd0, gnt0, gnt1, done0, mul_start}, 0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    saw_done0 = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      saw_done0 |= done0;
    end
    checkOutput("t5_no_done0", saw_done0, 0);
    applyStimulus(1, 16'd7, 16'd7, 0, 16'h0, 16'h0);
    pushExp(0, 16'd7, 16'd7);
    @(posedge clk); #1;
    applyStimulus(0, 16'd7, 16'd7, 0, 16'h0, 16'h0);
    waitDone(0, 40, lat);
    checkOutput("t5_latency", lat, DONE_EDGES);
    checkOutput("t5_res0_fresh", res0, 32'h0000_0031);

    // Zero operand
    $display("[TB] zero operand");
    @(posedge clk); #1;
    applyStimulus(1, 16'h0000, 16'h1234, 0, 16'h0, 16'h0);
    pushExp(0, 16'h0000, 16'h1234);
    @(posedge clk); #1;
    checkOutput("t6_gnt0", gnt0, 1);
    saw_ms = mul_start;
    applyStimulus(0, 16'h0000, 16'h1234, 0, 16'h0, 16'h0);
    lat = 0;
    while (!done0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      saw_ms |= mul_start;
    end
`ifdef BOOTH_ARB_ZERO_SKIP_EN
    checkOutput("t6_latency", lat, 1);
    checkOutput("t6_no_mul_start", saw_ms, 0);
`else
    checkOutput("t6_latency", lat, DONE_EDGES);
    checkOutput("t6_mul_start", saw_ms, 1);
`endif
    checkOutput("t6_res0", res0, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
